// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier.
// One registered Booth step (add/sub/skip, then arithmetic shift right) is
// reused once per clock for WIDTH+1 steps on operands extended to WIDTH+1
// bits. This lets one datapath cover both signed and unsigned operands.
//
// Handshake: start is sampled only in IDLE, together with signed_mode and
// both operands. busy is high for the WIDTH+1 RUN cycles. done is a
// one-cycle pulse in the first IDLE cycle after the run, and product holds
// its value until the next completion or reset. A start seen during that
// done cycle is accepted, which gives back-to-back operation.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q;
  logic [WIDTH:0]     a_q;
  logic [WIDTH+1:0]   q_q;
  logic [WIDTH:0]     mx_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH:0]     ext_m;
  logic [WIDTH:0]     ext_q;
  logic [WIDTH:0]     a_step;
  logic [WIDTH:0]     a_sh;
  logic [WIDTH+1:0]   q_sh;
  logic [2*WIDTH-1:0] product_d;

  // Operand extension and one Booth step: add/sub/skip, then shift {A,Q} right.
  always_comb begin
    ext_m = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    ext_q = {signed_mode & multiplier[WIDTH-1], multiplier};
    a_step = a_q;
    case (q_q[1:0])
      2'b01:   a_step = a_q + mx_q;
      2'b10:   a_step = a_q - mx_q;
      default: a_step = a_q;
    endcase
    a_sh      = {a_step[WIDTH], a_step[WIDTH:1]};
    q_sh      = {a_step[0], q_q[WIDTH+1:1]};
    // Low 2*WIDTH bits of {A, Q[WIDTH+1:1]} after the shift.
    product_d = {a_sh[WIDTH-2:0], q_sh[WIDTH+1:1]};
  end

  // Control FSM and datapath registers with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      mx_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mx_q    <= ext_m;
            q_q     <= {ext_q, 1'b0};
            a_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q   <= a_sh;
          q_q   <= q_sh;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            product_q <= product_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;
  assign dbg_state = (state_q == S_RUN);

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult at WIDTH=8.
// It covers a table of hand-computed products, a back-to-back sequence with
// start held high, a reset in the middle of a run, and random operands
// checked against the language's integer multiply.
module tb_booth_seq_mult;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           dbg_state;

  int vectors;
  int miscompares;

  typedef struct {
    logic         s;
    logic [7:0]   m;
    logic [7:0]   q;
    logic [15:0]  exp;
  } vec_t;

  vec_t vecs [15];

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .dbg_state    (dbg_state)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts edges until done is seen (sampled #1 after each edge), with a bound.
  // Also counts how many samples showed busy and flags busy && done.
  task automatic wait_done(output int lat, output int busy_cnt, input logic scramble);
    int both;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    both = 0;
    while (!done && lat < 40) begin
      if (scramble) begin
        multiplicand = W'($urandom_range(0, 255));
        multiplier   = W'($urandom_range(0, 255));
        signed_mode  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
      if (busy && done) both++;
    end
    check("busy_done_overlap", both, 0);
  endtask

  // One complete operation, with the operands scrambled during RUN.
  task automatic run_op(input logic s, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp);
    int lat;
    int bc;
    @(negedge clk);
    start        = 1'b1;
    signed_mode  = s;
    multiplicand = m;
    multiplier   = q;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc, 1'b1);
    check("latency", lat, 9);
    check("busy_cycles", bc, 9);
    check("product", {16'h0, product}, {16'h0, exp});
    @(posedge clk); #1;
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("product_hold", {16'h0, product}, {16'h0, exp});
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;
    vectors     = 0;
    miscompares = 0;

    // Hand-computed table: {signed_mode, M, Q, expected product}
    vecs[0]  = '{1'b1, 8'hFB, 8'h03, 16'hFFF1};
    vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[2]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[3]  = '{1'b1, 8'h00, 8'h80, 16'h0000};
    vecs[4]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[5]  = '{1'b0, 8'h80, 8'h02, 16'h0100};
    vecs[6]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[7]  = '{1'b1, 8'h80, 8'h02, 16'hFF00};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 16'h0000};
    vecs[9]  = '{1'b0, 8'h7F, 8'h7F, 16'h3F01};
    vecs[10] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[11] = '{1'b1, 8'h01, 8'h80, 16'hFF80};
    vecs[12] = '{1'b0, 8'h0F, 8'h10, 16'h00F0};
    vecs[13] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[14] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};

    // Reset
    rst_n        = 1'b0;
    start        = 1'b1;
    signed_mode  = 1'b0;
    multiplicand = 8'h12;
    multiplier   = 8'h34;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",    {31'h0, busy},      32'h0);
    check("reset_done",    {31'h0, done},      32'h0);
    check("reset_product", {16'h0, product},   32'h0);
    check("reset_state",   {31'h0, dbg_state}, 32'h0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) run_op(vecs[i].s, vecs[i].m, vecs[i].q, vecs[i].exp);

    // Back-to-back with start held high; operands are garbage mid-RUN
    // and only set to the next pair in the done cycle.
    @(negedge clk);
    start        = 1'b1;
    signed_mode  = 1'b1;
    multiplicand = 8'hFB;
    multiplier   = 8'h03;
    @(posedge clk); #1;
    wait_done(lat, bc, 1'b1);
    check("b2b_lat0", lat, 9);
    check("b2b_prod0", {16'h0, product}, 32'h0000FFF1);
    signed_mode  = 1'b0;
    multiplicand = 8'hFF;
    multiplier   = 8'hFF;
    @(posedge clk); #1;
    check("b2b_accept", {31'h0, busy}, 32'h1);
    wait_done(lat, bc, 1'b1);
    check("b2b_lat1", lat, 9);
    check("b2b_prod1", {16'h0, product}, 32'h0000FE01);
    signed_mode  = 1'b1;
    multiplicand = 8'h80;
    multiplier   = 8'h7F;
    @(posedge clk); #1;
    check("b2b_accept2", {31'h0, busy}, 32'h1);
    start = 1'b0;
    wait_done(lat, bc, 1'b1);
    check("b2b_lat2", lat, 9);
    check("b2b_prod2", {16'h0, product}, 32'h0000C080);

    // Reset at step 4 of a run: abort, no done, product cleared
    @(negedge clk);
    start        = 1'b1;
    signed_mode  = 1'b0;
    multiplicand = 8'h0F;
    multiplier   = 8'h10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy",    {31'h0, busy},    32'h0);
    check("abort_done",    {31'h0, done},    32'h0);
    check("abort_product", {16'h0, product}, 32'h0);
    done_seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_op(1'b0, 8'h0F, 8'h10, 16'h00F0);

    // Random operands against integer multiply
    for (int i = 0; i < 300; i++) begin
      logic        s;
      logic [7:0]  m;
      logic [7:0]  q;
      int          mi;
      int          qi;
      int          p;
      s  = 1'($urandom_range(0, 1));
      m  = 8'($urandom_range(0, 255));
      q  = 8'($urandom_range(0, 255));
      mi = s ? int'($signed(m)) : int'(m);
      qi = s ? int'($signed(q)) : int'(q);
      p  = mi * qi;
      run_op(s, m, q, p[15:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
